// File: rtl/stripe_pkg.sv
// Shared definitions for the stripe demultiplexer: default geometry, FSM
// state encoding and the lane slice offset helper.
package stripe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_LANES      = 4;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  // Bit offset of a lane inside the flattened lanes vector.
  function automatic int lane_offset(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/stripe_demux_if.sv
// Input word stream and parallel stripe-group output of the stripe demultiplexer.
interface stripe_demux_if
  import stripe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES
);

  logic [DATA_WIDTH-1:0]       din;
  logic                        din_valid;
  logic                        din_ready;
  logic                        flush;
  logic [LANES*DATA_WIDTH-1:0] lanes_out;
  logic [LANES-1:0]            lanes_mask;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output din, din_valid, flush, out_ready,
    input  din_ready, lanes_out, lanes_mask, out_valid
  );

  modport slave (
    input  din, din_valid, flush, out_ready,
    output din_ready, lanes_out, lanes_mask, out_valid
  );

endinterface

// File: rtl/stripe_out_reg.sv
// Output holding register for a stripe group; holds lanes and mask stable
// until the downstream side accepts them.
module stripe_out_reg #(
  parameter int WIDTH  = 128,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  lanes_in,
  input  logic [MASK_W-1:0] mask_in,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  lanes_out,
  output logic [MASK_W-1:0] mask_out,
  output logic              out_valid,
  output logic              free
);

  // Free when empty, or when the held group leaves on this edge.
  assign free = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_out <= '0;
      mask_out  <= '0;
      out_valid <= 1'b0;
    end else if (load && free) begin
      lanes_out <= lanes_in;
      mask_out  <= mask_in;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      // lanes_out keeps its last value after the group is consumed
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stripe_demux.sv
// Distributes accepted words round-robin across LANES lanes and hands each
// closed group to the output register as one parallel transfer.
module stripe_demux
  import stripe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES,
  parameter int PTR_W      = 3
) (
  input  logic            clk,
  input  logic            reset,
  stripe_demux_if.slave   bus,
  output logic [15:0]     group_count
);

  localparam int W = LANES * DATA_WIDTH;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]       acc_q, acc_d, merged;
  logic [LANES-1:0]   mask_q, mask_d, merged_mask;
  logic [15:0]        count_q;
  logic               accept, last, close, load, free, xfer;
  logic [W-1:0]       ol;
  logic [LANES-1:0]   om;
  logic               ov;

  // Ready is a function of state only, so there is no path from din_valid.
  assign bus.din_ready = (state_q == FILL);
  assign accept        = bus.din_valid && bus.din_ready;
  assign last          = (ptr_q == PTR_W'(LANES - 1));
  assign close         = (state_q == FILL) &&
                         ((accept && last) || (bus.flush && (ptr_q != '0 || accept)));
  assign xfer          = ov && bus.out_ready;

  // Accumulator contents including this cycle's word, if any.
  always_comb begin
    merged      = acc_q;
    merged_mask = mask_q;
    for (int k = 0; k < LANES; k++) begin
      if (accept && ptr_q == PTR_W'(k)) begin
        merged[lane_offset(k, DATA_WIDTH) +: DATA_WIDTH] = bus.din;
        merged_mask[k] = 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    load    = 1'b0;
    case (state_q)
      FILL: begin
        if (close) begin
          if (free) begin
            load   = 1'b1;
            acc_d  = '0;
            mask_d = '0;
            ptr_d  = '0;
          end else begin
            state_d = PEND;
            acc_d   = merged;
            mask_d  = merged_mask;
          end
        end else if (accept) begin
          acc_d  = merged;
          mask_d = merged_mask;
          ptr_d  = ptr_q + PTR_W'(1);
        end
      end
      PEND: begin
        if (free) begin
          load    = 1'b1;
          acc_d   = '0;
          mask_d  = '0;
          ptr_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the accumulator is reset, not just the pointer, because unfilled
  // lanes of a closed group must read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      ptr_q   <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      if (xfer) count_q <= count_q + 16'd1;
    end
  end

  stripe_out_reg #(
    .WIDTH  (W),
    .MASK_W (LANES)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .lanes_in  (merged),
    .mask_in   (merged_mask),
    .out_ready (bus.out_ready),
    .lanes_out (ol),
    .mask_out  (om),
    .out_valid (ov),
    .free      (free)
  );

  assign bus.lanes_out  = ol;
  assign bus.lanes_mask = om;
  assign bus.out_valid  = ov;
  assign group_count    = count_q;

endmodule

// File: tb/tb_stripe_demux.sv
// Self-checking bench for stripe_demux: directed scenarios plus randomized
// traffic scored against a word-list model of stripe grouping.
module tb_stripe_demux;
  import stripe_pkg::*;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int PW = 3;

  typedef struct packed {
    logic [LN*DW-1:0] lanes;
    logic [LN-1:0]    mask;
  } grp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] group_count;

  stripe_demux_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  stripe_demux #(.DATA_WIDTH(DW), .LANES(LN), .PTR_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .group_count (group_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          xfers  = 0;
  grp_t        exp_q[$];
  logic [DW-1:0] words[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: words collect in arrival order; a group closes at LN words or on
  // an accepted flush with at least one word pending.
  task automatic observe();
    grp_t g;
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_group: got lanes %h mask %b, required no group",
                 bus.lanes_out, bus.lanes_mask);
      end else begin
        g = exp_q.pop_front();
        if (bus.lanes_out !== g.lanes || bus.lanes_mask !== g.mask) begin
          errors++;
          $display("FAIL group_data: got %h/%b required %h/%b",
                   bus.lanes_out, bus.lanes_mask, g.lanes, g.mask);
        end
      end
      xfers++;
    end
    if (bus.din_valid && bus.din_ready) words.push_back(bus.din);
    if (bus.din_ready && words.size() > 0 && (words.size() == LN || bus.flush)) begin
      g = '0;
      for (int i = 0; i < words.size(); i++) begin
        g.lanes[i*DW +: DW] = words[i];
        g.mask[i] = 1'b1;
      end
      exp_q.push_back(g);
      words.delete();
    end
  endtask

  // Called at a negedge; applies inputs for the next rising edge and returns
  // at the following negedge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f,
                       input logic rdy);
    logic           hold;
    logic [LN*DW-1:0] hl;
    logic [LN-1:0]  hm;
    bus.din_valid = v;
    bus.din       = d;
    bus.flush     = f;
    bus.out_ready = rdy;
    #1;
    hold = bus.out_valid && !rdy;
    hl   = bus.lanes_out;
    hm   = bus.lanes_mask;
    observe();
    @(negedge clk);
    if (hold) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.lanes_out !== hl || bus.lanes_mask !== hm) begin
        errors++;
        $display("FAIL hold_stable: got %b/%h/%b required 1/%h/%b",
                 bus.out_valid, bus.lanes_out, bus.lanes_mask, hl, hm);
      end
    end
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.din       = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    words.delete();
    xfers = 0;
  endtask

  task automatic check_count(input string name);
    checks++;
    if (group_count !== 16'(xfers)) begin
      errors++;
      $display("FAIL %s: got group_count %h required %h", name, group_count, 16'(xfers));
    end
  endtask

  task automatic test_reset();
    // Leave a group held and a partial group pending, then reset.
    for (int i = 1; i <= 6; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.lanes_out !== '0 || bus.lanes_mask !== '0) begin
      errors++;
      $display("FAIL reset_out: got %b/%h/%b required 0/0/0",
               bus.out_valid, bus.lanes_out, bus.lanes_mask);
    end
    checks++;
    if (bus.din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", bus.din_ready);
    end
    check_count("reset_count");
    // The discarded partial group must never appear.
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_group: got out_valid %b required 0", bus.out_valid);
    end
  endtask

  task automatic test_basic();
    logic [LN*DW-1:0] e;
    do_reset();
    drive(1'b1, 32'h11, 1'b0, 1'b1);
    drive(1'b1, 32'h22, 1'b0, 1'b1);
    drive(1'b1, 32'h33, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got out_valid %b required 0", bus.out_valid);
    end
    drive(1'b1, 32'h44, 1'b0, 1'b1);
    e = {32'h44, 32'h33, 32'h22, 32'h11};
    checks++;
    if (bus.out_valid !== 1'b1 || bus.lanes_out !== e || bus.lanes_mask !== 4'hF) begin
      errors++;
      $display("FAIL basic_group: got %b/%h/%b required 1/%h/1111",
               bus.out_valid, bus.lanes_out, bus.lanes_mask, e);
    end
    drive(1'b0, DW'($urandom), 1'b0, 1'b1);
    check_count("basic_count");
    checks++;
    if (bus.out_valid !== 1'b0 || bus.lanes_out !== e) begin
      errors++;
      $display("FAIL basic_after: got %b/%h required 0/%h", bus.out_valid, bus.lanes_out, e);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.din_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready: word %0d got %b required 1", i, bus.din_ready);
      end
      drive(1'b1, DW'(i), 1'b0, 1'b1);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check_count("stream_count");
    checks++;
    if (xfers != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_groups: got %0d transfers %0d pending required 2 and 0",
               xfers, exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [LN*DW-1:0] e;
    do_reset();
    drive(1'b1, 32'hA, 1'b0, 1'b1);
    drive(1'b1, 32'hB, 1'b0, 1'b1);
    drive(1'b0, DW'($urandom), 1'b1, 1'b1);
    e = {32'h0, 32'h0, 32'hB, 32'hA};
    checks++;
    if (bus.out_valid !== 1'b1 || bus.lanes_out !== e || bus.lanes_mask !== 4'b0011) begin
      errors++;
      $display("FAIL flush_group: got %b/%h/%b required 1/%h/0011",
               bus.out_valid, bus.lanes_out, bus.lanes_mask, e);
    end
    drive(1'b0, DW'($urandom), 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got out_valid %b required 0", bus.out_valid);
    end
    check_count("flush_count");
  endtask

  task automatic test_back_pressure();
    logic [LN*DW-1:0] e1, e2;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.din_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready: word %0d got %b required 1", i, bus.din_ready);
      end
      drive(1'b1, DW'(i), 1'b0, 1'b0);
    end
    e1 = {32'h4, 32'h3, 32'h2, 32'h1};
    e2 = {32'h8, 32'h7, 32'h6, 32'h5};
    checks++;
    if (bus.din_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.lanes_out !== e1) begin
      errors++;
      $display("FAIL bp_pend: got ready %b valid %b lanes %h required 0 1 %h",
               bus.din_ready, bus.out_valid, bus.lanes_out, e1);
    end
    // Word and flush offered while pending are both ignored.
    drive(1'b1, 32'h99, 1'b1, 1'b0);
    checks++;
    if (bus.din_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_pend_hold: got ready %b required 0", bus.din_ready);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.lanes_out !== e2 || bus.lanes_mask !== 4'hF ||
        bus.din_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got %b/%h/%b ready %b required 1/%h/1111 ready 1",
               bus.out_valid, bus.lanes_out, bus.lanes_mask, bus.din_ready, e2);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    check_count("bp_count");
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    drive(1'b1, 32'h1, 1'b0, 1'b1);
    drive(1'b1, 32'h2, 1'b0, 1'b1);
    do_reset();
    for (int i = 5; i <= 8; i++) drive(1'b1, DW'(i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check_count("midreset_count");
    checks++;
    if (xfers != 1) begin
      errors++;
      $display("FAIL midreset_groups: got %0d transfers required 1", xfers);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    xfers = 16'hFFFF;
    for (int i = 0; i < LN; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (group_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap: got %h required 0000", group_count);
    end
  endtask

  task automatic test_random();
    logic v, f, r;
    int   n;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(3) != 0);
      f = ($urandom_range(7) == 0);
      r = ($urandom_range(2) != 0);
      drive(v, DW'($urandom), f, r);
    end
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && n < 20) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d pending valid %b required 0 pending valid 0",
               exp_q.size(), bus.out_valid);
    end
    check_count("random_count");
  endtask

  initial begin
    reset         = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_flush();
    test_back_pressure();
    test_reset_mid_group();
    test_count_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
